// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, drives the imem req/ack port and
// holds one fetched instruction for decode; handles stall, redirect and timeout.
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        branch_flag_i,
  input  logic [31:0] branch_target_i,
  input  logic        flush_i,
  input  logic [31:0] flush_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_rdata_i,
  output logic        inst_valid_o,
  output logic [31:0] inst_o,
  output logic [31:0] inst_pc_o,
  output logic [31:0] pc_o,
  output logic        ce_o,
  output logic        fetch_err_o
);

  typedef enum logic [1:0] {BOOT, IDLE, WAIT, ERR} state_t;

  localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

  state_t      state;
  logic [31:0] pc;
  logic [31:0] redir_pc;
  logic [31:0] inst_q;
  logic [31:0] inst_pc_q;
  logic        kill;
  logic        ce_q;
  logic        valid_q;
  logic        err_q;
  logic [7:0]  wait_cnt;

  logic [31:0] redir_sel;
  logic [31:0] redir_tgt;
  logic        redir_en;
  logic        consume;

  // Flush outranks branch; a branch is meaningless once fetch has faulted.
  always_comb begin
    redir_sel = flush_i ? flush_pc_i : branch_target_i;
    redir_tgt = {redir_sel[31:2], 2'b00};
    redir_en  = flush_i || (branch_flag_i && (state != ERR));
    consume   = valid_q && !stall_i;
  end

  assign imem_req_o   = (state == WAIT);
  assign imem_addr_o  = pc;
  assign pc_o         = pc;
  assign ce_o         = ce_q;
  assign inst_valid_o = valid_q;
  assign inst_o       = inst_q;
  assign inst_pc_o    = inst_pc_q;
  assign fetch_err_o  = err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= BOOT;
      pc        <= RESET_PC;
      redir_pc  <= '0;
      inst_q    <= '0;
      inst_pc_q <= '0;
      kill      <= 1'b0;
      ce_q      <= 1'b0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
      wait_cnt  <= '0;
    end else begin
      // Later assignments in the case (capture, redirect) override consumption.
      if (consume) valid_q <= 1'b0;

      unique case (state)
        BOOT: begin
          ce_q  <= 1'b1;
          state <= IDLE;
          if (redir_en) begin
            pc      <= redir_tgt;
            valid_q <= 1'b0;
          end
        end

        IDLE: begin
          if (redir_en) begin
            pc      <= redir_tgt;
            valid_q <= 1'b0;
          end else if (!valid_q || !stall_i) begin
            state    <= WAIT;
            wait_cnt <= '0;
          end
        end

        WAIT: begin
          if (imem_ack_i) begin
            state <= IDLE;
            kill  <= 1'b0;
            if (redir_en) begin
              pc      <= redir_tgt;
              valid_q <= 1'b0;
            end else if (kill) begin
              pc <= redir_pc;
            end else begin
              inst_q    <= imem_rdata_i;
              inst_pc_q <= pc;
              valid_q   <= 1'b1;
              pc        <= pc + 32'd4;
            end
          end else begin
            // Request must stay stable, so a redirect is parked until the ack.
            if (redir_en) begin
              kill     <= 1'b1;
              redir_pc <= redir_tgt;
              valid_q  <= 1'b0;
            end
            if (wait_cnt == WAIT_LAST) begin
              state <= ERR;
              err_q <= 1'b1;
            end else begin
              wait_cnt <= wait_cnt + 8'd1;
            end
          end
        end

        ERR: begin
          if (flush_i) begin
            pc      <= redir_tgt;
            err_q   <= 1'b0;
            kill    <= 1'b0;
            valid_q <= 1'b0;
            state   <= IDLE;
          end
        end

        default: state <= BOOT;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed vector table, hand-written
// corner sequences, then randomized traffic against a behavioural model.
module tb_fetch_ctrl;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam int          MW     = 15;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_i, branch_flag_i, flush_i, imem_ack_i;
  logic [31:0] branch_target_i, flush_pc_i, imem_rdata_i;
  logic        imem_req_o, inst_valid_o, ce_o, fetch_err_o;
  logic [31:0] imem_addr_o, inst_o, inst_pc_o, pc_o;

  int checks = 0;
  int errors = 0;

  fetch_ctrl #(.RESET_PC(RST_PC), .MAX_WAIT(MW)) dut (
    .clk(clk), .rst(rst),
    .stall_i(stall_i),
    .branch_flag_i(branch_flag_i), .branch_target_i(branch_target_i),
    .flush_i(flush_i), .flush_pc_i(flush_pc_i),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
    .imem_ack_i(imem_ack_i), .imem_rdata_i(imem_rdata_i),
    .inst_valid_o(inst_valid_o), .inst_o(inst_o), .inst_pc_o(inst_pc_o),
    .pc_o(pc_o), .ce_o(ce_o), .fetch_err_o(fetch_err_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        stall;
    logic        br;
    logic [31:0] bt;
    logic        fl;
    logic [31:0] fp;
    logic        ack;
    logic [31:0] rd;
    logic        req;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] inst;
    logic [31:0] ipc;
  } vec_t;

  vec_t vecs[24];

  function automatic vec_t mk(logic st, logic br, logic [31:0] bt, logic fl,
                              logic [31:0] fp, logic ack, logic [31:0] rd,
                              logic req, logic [31:0] addr, logic valid,
                              logic [31:0] inst, logic [31:0] ipc);
    vec_t v;
    v.stall = st; v.br = br; v.bt = bt; v.fl = fl; v.fp = fp;
    v.ack = ack; v.rd = rd; v.req = req; v.addr = addr; v.valid = valid;
    v.inst = inst; v.ipc = ipc;
    return v;
  endfunction

  task automatic chk(input string tag, input string fld,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s %s: actual %h required %h", tag, fld, act, exp);
    end
  endtask

  task automatic expect_all(input string tag, input logic req, input logic [31:0] addr,
                            input logic valid, input logic [31:0] inst,
                            input logic [31:0] ipc, input logic err, input logic ce);
    chk(tag, "req",   imem_req_o,   req);
    chk(tag, "addr",  imem_addr_o,  addr);
    chk(tag, "pc",    pc_o,         addr);
    chk(tag, "valid", inst_valid_o, valid);
    chk(tag, "inst",  inst_o,       inst);
    chk(tag, "ipc",   inst_pc_o,    ipc);
    chk(tag, "err",   fetch_err_o,  err);
    chk(tag, "ce",    ce_o,         ce);
  endtask

  // Apply one cycle of inputs (held from here past the next rising edge), then
  // return 1 time unit after that edge, where outputs are sampled.
  task automatic drive(input logic st, input logic br, input logic [31:0] bt,
                       input logic fl, input logic [31:0] fp,
                       input logic ack, input logic [31:0] rd);
    stall_i = st; branch_flag_i = br; branch_target_i = bt;
    flush_i = fl; flush_pc_i = fp; imem_ack_i = ack; imem_rdata_i = rd;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycle();
    drive(1'b0, 1'b0, '0, 1'b0, '0, 1'b0, '0);
  endtask

  // ---------------- behavioural reference for the random phase ----------------
  function automatic logic [31:0] mem_word(logic [31:0] a);
    return {a[7:0], a[31:8]} ^ 32'h9E37_79B9;
  endfunction

  bit          m_boot, m_busy, m_err, m_valid, m_kill, m_ce;
  logic [31:0] m_pc, m_inst, m_ipc, m_rpc;
  int          m_waited;

  task automatic model_reset();
    m_boot = 1; m_busy = 0; m_err = 0; m_valid = 0; m_kill = 0; m_ce = 0;
    m_pc = RST_PC; m_inst = '0; m_ipc = '0; m_rpc = '0; m_waited = 0;
  endtask

  task automatic model_edge(input bit st, input bit br, input logic [31:0] bt,
                            input bit fl, input logic [31:0] fp, input bit ack);
    logic [31:0] tgt;
    bit redirect;
    bit next_valid;
    tgt        = (fl ? fp : bt) & 32'hFFFF_FFFC;
    redirect   = fl || (br && !m_err);
    next_valid = m_valid && st;
    if (m_boot) begin
      m_boot = 0;
      m_ce   = 1;
      if (redirect) m_pc = tgt;
    end else if (m_err) begin
      if (fl) begin
        m_err = 0; m_kill = 0; m_pc = tgt; next_valid = 0;
      end
    end else if (m_busy) begin
      if (ack) begin
        m_busy = 0;
        if (redirect) begin
          m_pc = tgt; next_valid = 0;
        end else if (m_kill) begin
          m_pc = m_rpc;
        end else begin
          m_inst = mem_word(m_pc); m_ipc = m_pc; next_valid = 1;
          m_pc = m_pc + 32'd4;
        end
        m_kill = 0;
      end else begin
        if (redirect) begin
          m_kill = 1; m_rpc = tgt; next_valid = 0;
        end
        m_waited++;
        if (m_waited == MW) begin
          m_busy = 0; m_err = 1;
        end
      end
    end else begin
      if (redirect) begin
        m_pc = tgt; next_valid = 0;
      end else if (!m_valid || !st) begin
        m_busy = 1; m_waited = 0;
      end
    end
    if (redirect) next_valid = 0;
    m_valid = next_valid;
  endtask

  function automatic logic [31:0] rand_tgt();
    logic [31:0] t;
    t = $urandom();
    if ($urandom_range(0, 3) == 0) t = 32'hFFFF_FFF0 | (t & 32'hF);
    return t;
  endfunction

  initial begin
    bit dead;
    bit st, br, fl, ak;
    logic [31:0] bt, fp, rd;

    rst = 1'b1;
    stall_i = 0; branch_flag_i = 0; branch_target_i = '0;
    flush_i = 0; flush_pc_i = '0; imem_ack_i = 0; imem_rdata_i = '0;

    vecs[0]  = mk(0,0,'0,0,'0, 0,'0,           0,32'h0,   0,32'h0,        32'h0);
    vecs[1]  = mk(0,0,'0,0,'0, 0,'0,           1,32'h0,   0,32'h0,        32'h0);
    vecs[2]  = mk(0,0,'0,0,'0, 1,32'h00000013, 0,32'h4,   1,32'h00000013, 32'h0);
    vecs[3]  = mk(0,0,'0,0,'0, 0,'0,           1,32'h4,   0,32'h00000013, 32'h0);
    vecs[4]  = mk(0,0,'0,0,'0, 1,32'h11111111, 0,32'h8,   1,32'h11111111, 32'h4);
    vecs[5]  = mk(0,0,'0,0,'0, 0,'0,           1,32'h8,   0,32'h11111111, 32'h4);
    vecs[6]  = mk(0,0,'0,0,'0, 1,32'h22222222, 0,32'hC,   1,32'h22222222, 32'h8);
    vecs[7]  = mk(0,0,'0,0,'0, 0,'0,           1,32'hC,   0,32'h22222222, 32'h8);
    vecs[8]  = mk(0,0,'0,0,'0, 1,32'h24010001, 0,32'h10,  1,32'h24010001, 32'hC);
    for (int k = 9; k < 14; k++)
      vecs[k] = mk(1,0,'0,0,'0, 0,'0,          0,32'h10,  1,32'h24010001, 32'hC);
    vecs[14] = mk(0,0,'0,0,'0, 0,'0,           1,32'h10,  0,32'h24010001, 32'hC);
    vecs[15] = mk(0,1,32'h103,0,'0, 0,'0,      1,32'h10,  0,32'h24010001, 32'hC);
    vecs[16] = mk(0,0,'0,0,'0, 0,'0,           1,32'h10,  0,32'h24010001, 32'hC);
    vecs[17] = mk(0,0,'0,0,'0, 0,'0,           1,32'h10,  0,32'h24010001, 32'hC);
    vecs[18] = mk(0,0,'0,0,'0, 1,32'hDEADBEEF, 0,32'h100, 0,32'h24010001, 32'hC);
    vecs[19] = mk(0,0,'0,0,'0, 0,'0,           1,32'h100, 0,32'h24010001, 32'hC);
    vecs[20] = mk(0,0,'0,0,'0, 1,32'hAAAA0000, 0,32'h104, 1,32'hAAAA0000, 32'h100);
    vecs[21] = mk(0,1,32'h40,1,32'h180, 0,'0,  0,32'h180, 0,32'hAAAA0000, 32'h100);
    vecs[22] = mk(0,0,'0,0,'0, 0,'0,           1,32'h180, 0,32'hAAAA0000, 32'h100);
    vecs[23] = mk(0,0,'0,0,'0, 1,32'hBBBB0000, 0,32'h184, 1,32'hBBBB0000, 32'h180);

    repeat (2) @(posedge clk);
    #1;
    expect_all("reset", 0, RST_PC, 0, '0, '0, 0, 0);
    rst = 1'b0;

    for (int i = 0; i < 24; i++) begin
      drive(vecs[i].stall, vecs[i].br, vecs[i].bt, vecs[i].fl, vecs[i].fp,
            vecs[i].ack, vecs[i].rd);
      expect_all($sformatf("vec%0d", i), vecs[i].req, vecs[i].addr, vecs[i].valid,
                 vecs[i].inst, vecs[i].ipc, 0, 1);
    end

    // Timeout: MW cycles in WAIT with no ack, branch ignored, flush recovers.
    idle_cycle();
    expect_all("to_issue", 1, 32'h184, 0, 32'hBBBB0000, 32'h180, 0, 1);
    for (int i = 1; i < MW; i++) begin
      idle_cycle();
      expect_all($sformatf("to_wait%0d", i), 1, 32'h184, 0, 32'hBBBB0000, 32'h180, 0, 1);
    end
    idle_cycle();
    expect_all("to_err", 0, 32'h184, 0, 32'hBBBB0000, 32'h180, 1, 1);
    drive(0, 1, 32'h40, 0, '0, 0, '0);
    expect_all("err_branch", 0, 32'h184, 0, 32'hBBBB0000, 32'h180, 1, 1);
    drive(0, 0, '0, 1, 32'h180, 0, '0);
    expect_all("err_flush", 0, 32'h180, 0, 32'hBBBB0000, 32'h180, 0, 1);
    idle_cycle();
    expect_all("err_reissue", 1, 32'h180, 0, 32'hBBBB0000, 32'h180, 0, 1);
    drive(0, 0, '0, 0, '0, 1, 32'hCAFE0000);
    expect_all("err_fetch", 0, 32'h184, 1, 32'hCAFE0000, 32'h180, 0, 1);

    // PC wrap at the top of the address space; target low bits are dropped.
    drive(0, 1, 32'hFFFFFFFE, 0, '0, 0, '0);
    expect_all("wrap_redir", 0, 32'hFFFFFFFC, 0, 32'hCAFE0000, 32'h180, 0, 1);
    idle_cycle();
    expect_all("wrap_req", 1, 32'hFFFFFFFC, 0, 32'hCAFE0000, 32'h180, 0, 1);
    drive(0, 0, '0, 0, '0, 1, 32'h12345678);
    expect_all("wrap_ack", 0, 32'h0, 1, 32'h12345678, 32'hFFFFFFFC, 0, 1);
    idle_cycle();
    expect_all("post_wrap_req", 1, 32'h0, 0, 32'h12345678, 32'hFFFFFFFC, 0, 1);
    drive(0, 0, '0, 0, '0, 1, 32'h87654321);
    expect_all("post_wrap_ack", 0, 32'h4, 1, 32'h87654321, 32'h0, 0, 1);
    idle_cycle();
    idle_cycle();
    expect_all("pre_reset_wait", 1, 32'h4, 0, 32'h87654321, 32'h0, 0, 1);

    // Asynchronous reset in mid-request; an ack arriving during BOOT is ignored.
    #3 rst = 1'b1;
    #1;
    expect_all("async_reset", 0, RST_PC, 0, '0, '0, 0, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    drive(0, 0, '0, 0, '0, 1, 32'hFFFF0000);
    expect_all("late_ack", 0, RST_PC, 0, '0, '0, 0, 1);
    idle_cycle();
    expect_all("boot_req", 1, RST_PC, 0, '0, '0, 0, 1);
    drive(0, 0, '0, 0, '0, 1, 32'h00C0FFEE);
    expect_all("boot_fetch", 0, RST_PC + 32'd4, 1, 32'h00C0FFEE, RST_PC, 0, 1);

    // Randomized traffic against the reference model.
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    dead = 0;
    for (int c = 0; c < 3000; c++) begin
      if (!m_busy) dead = ($urandom_range(0, 39) == 0);
      st = ($urandom_range(0, 9) < 3);
      br = ($urandom_range(0, 99) < 6);
      fl = ($urandom_range(0, 99) < 3);
      bt = rand_tgt();
      fp = rand_tgt();
      if (m_busy) ak = !dead && ($urandom_range(0, 99) < 45);
      else        ak = ($urandom_range(0, 99) < 3);
      rd = ak ? mem_word(imem_addr_o) : $urandom();
      drive(st, br, bt, fl, fp, ak, rd);
      model_edge(st, br, bt, fl, fp, ak);
      expect_all($sformatf("rand%0d", c), m_busy, m_pc, m_valid, m_inst, m_ipc,
                 m_err, m_ce);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Instruction-fetch sequencer that owns the program counter.
- Issues requests to instruction memory over a req/ack handshake and holds one fetched instruction in an output register for the decode stage.
- Honours pipeline stall, branch redirect and exception flush.
- Detects instruction-memory timeouts.
- Sits between the pipeline control logic and the instruction memory port at the front of the pipeline.

Parameters:
RESET_PC, 32'h00000000, fetch address after reset
MAX_WAIT, 15, cycles in WAIT without ack before timeout error (1..255)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous reset, active-high
stall_i  input  1  decode stage cannot accept; output register must hold
branch_flag_i  input  1  one-cycle pulse: redirect fetch to branch_target_i
branch_target_i  input  32  branch target address
flush_i  input  1  one-cycle pulse: exception flush to flush_pc_i
flush_pc_i  input  32  exception handler address
imem_req_o  output  1  memory request valid
imem_addr_o  output  32  memory request address
imem_ack_i  input  1  memory response valid, one cycle
imem_rdata_i  input  32  instruction data, valid with ack
inst_valid_o  output  1  output register holds a valid instruction
inst_o  output  32  fetched instruction
inst_pc_o  output  32  address of inst_o
pc_o  output  32  next fetch address
ce_o  output  1  fetch enabled
fetch_err_o  output  1  sticky timeout error

Behaviour:
- Reset (async, rst=1):
  - state=BOOT, pc=RESET_PC, ce_o=0, imem_req_o=0.
  - inst_valid_o=0, inst_o=0, inst_pc_o=0, fetch_err_o=0.
  - kill=0, redir_pc=0, wait_cnt=0.
  - Reset asserted mid-request abandons the request; a late ack after reset is ignored (BOOT/IDLE ignore ack).
- States: BOOT, IDLE, WAIT, ERR.
  - imem_req_o=1 only in WAIT.
  - imem_addr_o=pc at all times.
- BOOT: one cycle after reset release; ce_o<=1; go IDLE.
- IDLE: if (!inst_valid_o || !stall_i), go WAIT and clear wait_cnt; else hold.
- WAIT:
  - req and addr stay stable until ack.
  - wait_cnt increments each cycle without ack.
  - Normal ack (kill=0):
    - inst_o<=imem_rdata_i, inst_pc_o<=pc, inst_valid_o<=1.
    - pc<=pc+4 (32-bit wrap, FFFFFFFC -> 00000000).
    - Go IDLE.
  - Ack with kill=1: discard data, pc<=redir_pc, kill<=0, go IDLE.
  - wait_cnt reaches MAX_WAIT with no ack: go ERR, fetch_err_o<=1.
- Throughput: with a zero-wait memory, one instruction per 2 cycles; first request issued 2 cycles after reset release.
- Consumption: when inst_valid_o=1, stall_i=0 and no capture this cycle, inst_valid_o<=0.
  - Issue only when the slot is free or being consumed, so a capture never overwrites a valid instruction.
- Redirect (flush_i, else branch_flag_i; flush wins if both asserted):
  - Target is the low-2-bit-cleared address.
  - inst_valid_o<=0 in the same edge, regardless of stall_i.
  - BOOT: takes effect; pc<=target.
  - IDLE: pc<=target.
  - WAIT without ack: kill<=1, redir_pc<=target; a later redirect overwrites redir_pc.
  - WAIT with ack in the same cycle: data discarded, pc<=target, go IDLE.
  - ERR: only flush_i exits; pc<=target, fetch_err_o<=0, go IDLE; branch_flag_i ignored.
- stall_i never blocks a redirect. stall_i in WAIT does not cancel the request; the captured instruction waits in the output register.
- ERR: imem_req_o=0, ce_o=1; inst_valid_o holds unless consumed.

Test Plan:
- Reset release, ack one cycle after each req, stall_i=0 -> first req at cycle 2 with addr 0; inst_pc_o sequence 0,4,8,C on alternating cycles; pc_o increments by 4 after each ack.
- stall_i=1 for 5 cycles with instruction 0x24010001 valid -> inst_o/inst_valid_o hold; no new req until stall_i=0; next addr is previous+4.
- branch_flag_i pulse to 0x00000103 while req to 0x10 is pending, ack 3 cycles later -> data discarded, inst_valid_o=0; next req addr 0x00000100.
- flush_i to 0x180 and branch_flag_i to 0x40 in the same cycle during IDLE -> next req addr 0x180.
- MAX_WAIT=15, ack never arrives -> imem_req_o drops and fetch_err_o=1 after 15 wait cycles; flush_i to 0x180 -> fetch_err_o=0, req to 0x180.
- pc=0xFFFFFFFC ack -> pc_o=0x00000000; assert rst mid-WAIT, ack after release -> ack ignored, first req addr RESET_PC.
